// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/EPC/IR holder and imem fetch handshake feeding decode, with next-PC selection on completion
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  output logic        first_cycle,
  input  logic        next_pc_valid,
  input  logic [1:0]  pc_sel,
  input  logic [1:0]  fin_pc,
  input  logic        br_taken,
  input  logic [15:0] imm,
  input  logic [15:0] rs_plus_imm,
  input  logic        exc_req,
  output logic        halted,
  output logic        err
);
  typedef enum logic [1:0] {START, FETCH, ISSUED, HALTED} phase;
  phase state;
  logic [15:0] pc, epc, ir, inc, tgt;
  logic halt;
  assign inc = pc + 16'd2;
  assign imem_addr = pc;
  assign pc_out = pc;
  assign pc_plus2 = inc;
  assign instr = ir;
  assign halt = !exc_req && fin_pc == 2'b10;
  always_comb begin
    tgt = exc_req ? EXC_VECTOR :
          fin_pc == 2'b01 ? epc :
          pc_sel == 2'b00 ? rs_plus_imm :
          pc_sel == 2'b01 ? (br_taken ? inc + imm : inc) :
          pc_sel == 2'b10 ? inc : inc + imm;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= START;
      pc <= RESET_PC;
      epc <= 16'h0000;
      ir <= 16'h0800;
      err <= 1'b0;
      imem_rd <= 1'b0;
      instr_valid <= 1'b0;
      first_cycle <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        START: begin
          first_cycle <= !first_cycle;
          if (first_cycle) begin
            state <= FETCH;
            imem_rd <= 1'b1;
          end
        end
        FETCH: if (imem_valid) begin
          ir <= imem_rdata;
          state <= ISSUED;
          imem_rd <= 1'b0;
          instr_valid <= 1'b1;
        end
        ISSUED: if (next_pc_valid) begin
          instr_valid <= 1'b0;
          if (halt || tgt[0]) begin
            state <= HALTED;
            halted <= 1'b1;
            err <= err | !halt;
          end else begin
            pc <= tgt;
            state <= FETCH;
            imem_rd <= 1'b1;
            if (exc_req) epc <= inc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
